// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants, FSM state
// encoding and the two-word opcode decode.
package instr_fetch_unit_pkg;

  localparam logic [15:0] OP_SETN    = 16'd0;
  localparam logic [15:0] OP_SETC    = 16'd1;
  localparam logic [15:0] OP_JNPZ    = 16'd21;
  localparam logic [15:0] OP_END     = 16'd25;
  localparam logic [15:0] MAX_OPCODE = 16'd28;

  localparam int N_TWO_WORD = 3;
  localparam logic [15:0] TWO_WORD_OPS [N_TWO_WORD] = '{OP_SETN, OP_SETC, OP_JNPZ};

  // IDLE is encoded as zero so the debug state output reads 0 during reset.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    FETCH_ARG = 3'd2,
    ISSUE     = 3'd3,
    WAIT_BR   = 3'd4,
    HALT      = 3'd5
  } state_t;

  function automatic logic is_two_word(input logic [15:0] opcode);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_TWO_WORD; i++) begin
      hit = hit | (opcode == TWO_WORD_OPS[i]);
    end
    return hit;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load, 16-bit wrapping increment and the check
// against the instruction memory depth.
module fetch_pc_reg #(
  parameter int unsigned IMEM_DEPTH = 100,
  parameter logic [15:0] START_ADDR = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_inc,
  output logic [15:0] o_pc,
  output logic        o_pc_out_of_range
);

  logic [15:0] r_pc;

  // Load wins over increment; 0xFFFF + 1 wraps to 0 by the 16-bit add.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= START_ADDR;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + 16'd1;
    end
  end

  assign o_pc              = r_pc;
  assign o_pc_out_of_range = ({16'd0, r_pc} >= IMEM_DEPTH);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one- and two-word instructions from a combinational instruction
// memory, presents them to execute and waits for JNPZ resolution.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 100,
  parameter logic [15:0] START_ADDR = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_opcode,
  output logic [15:0] instr_operand,
  output logic        instr_has_operand,
  input  logic        br_resolve,
  input  logic        br_taken,
  output logic [15:0] pc,
  output logic        halted,
  output logic        fault,
  output state_t      dbg_state
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_opcode;
  logic [15:0] r_operand;
  logic        r_fault;

  logic        w_pc_load;
  logic [15:0] w_pc_load_val;
  logic        w_pc_inc;
  logic [15:0] w_pc;
  logic        w_pc_oor;
  logic        w_imem_read;
  logic        w_instr_valid;
  logic        w_latch_op;
  logic        w_latch_arg;
  logic        w_set_fault;
  logic        w_has_operand;

  fetch_pc_reg #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_load            (w_pc_load),
    .i_load_val        (w_pc_load_val),
    .i_inc             (w_pc_inc),
    .o_pc              (w_pc),
    .o_pc_out_of_range (w_pc_oor)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake: in ISSUE, instr_valid stays high and the instruction fields stay
  // stable until a rising edge with instr_ready high transfers it; nothing else
  // moves the FSM out of ISSUE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (start) w_next_state = FETCH_OP;
      FETCH_OP: begin
        if (w_pc_oor || (imem_data > MAX_OPCODE)) begin
          w_next_state = HALT;
        end else if (is_two_word(imem_data)) begin
          w_next_state = FETCH_ARG;
        end else begin
          w_next_state = ISSUE;
        end
      end
      FETCH_ARG: w_next_state = w_pc_oor ? HALT : ISSUE;
      ISSUE: begin
        if (instr_ready) begin
          if (r_opcode == OP_END) begin
            w_next_state = HALT;
          end else if (r_opcode == OP_JNPZ) begin
            w_next_state = WAIT_BR;
          end else begin
            w_next_state = FETCH_OP;
          end
        end
      end
      WAIT_BR:   if (br_resolve) w_next_state = FETCH_OP;
      HALT:      w_next_state = HALT;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_pc_load     = 1'b0;
    w_pc_load_val = START_ADDR;
    w_pc_inc      = 1'b0;
    w_imem_read   = 1'b0;
    w_instr_valid = 1'b0;
    w_latch_op    = 1'b0;
    w_latch_arg   = 1'b0;
    w_set_fault   = 1'b0;
    case (r_state)
      IDLE:      w_pc_load = start;
      FETCH_OP: begin
        if (w_pc_oor) begin
          w_set_fault = 1'b1;
        end else begin
          w_imem_read = 1'b1;
          w_latch_op  = 1'b1;
          w_pc_inc    = 1'b1;
          w_set_fault = (imem_data > MAX_OPCODE);
        end
      end
      FETCH_ARG: begin
        if (w_pc_oor) begin
          w_set_fault = 1'b1;
        end else begin
          w_imem_read = 1'b1;
          w_latch_arg = 1'b1;
          w_pc_inc    = 1'b1;
        end
      end
      ISSUE:     w_instr_valid = 1'b1;
      WAIT_BR: begin
        w_pc_load     = br_resolve & br_taken;
        w_pc_load_val = r_operand;
      end
      default: ;
    endcase
  end

  // Operand is cleared on every opcode fetch so one-word instructions carry 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode  <= 16'd0;
      r_operand <= 16'd0;
      r_fault   <= 1'b0;
    end else begin
      if (w_latch_op) begin
        r_opcode  <= imem_data;
        r_operand <= 16'd0;
      end
      if (w_latch_arg) begin
        r_operand <= imem_data;
      end
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign w_has_operand     = (r_state == ISSUE) && is_two_word(r_opcode);
  assign imem_read         = w_imem_read;
  assign imem_address      = w_pc;
  assign instr_valid       = w_instr_valid;
  assign instr_opcode      = r_opcode;
  assign instr_operand     = w_has_operand ? r_operand : 16'd0;
  assign instr_has_operand = w_has_operand;
  assign pc                = w_pc;
  assign halted            = (r_state == HALT);
  assign fault             = r_fault;
  assign dbg_state         = r_state;

endmodule
